// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter funnelling N_REQ requesters into one
// registered FIFO enqueue port with full-throughput drain/reload.
module fifo_enq_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ENTRY_WIDTH = 4,
    parameter int ID_WIDTH    = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*ENTRY_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         fifo_enq_valid,
    output logic [ENTRY_WIDTH-1:0]       fifo_enq_data,
    input  logic                         fifo_enq_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [ID_WIDTH-1:0]          rr_ptr_state
);
    logic                   out_valid_q, out_valid_d;
    logic [ENTRY_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    gnt, idx;
    logic                   found, load_en, hs;

    // N_REQ is a power of two, so ID_WIDTH-bit addition wraps for free
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_ptr_q + ID_WIDTH'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign load_en   = !out_valid_q || fifo_enq_ready;
    assign hs        = found && load_en && !rst;
    assign req_ready = hs ? N_REQ'(1) << gnt : '0;

    always_comb begin
        out_valid_d = hs ? 1'b1 : (fifo_enq_ready ? 1'b0 : out_valid_q);
        out_data_d  = hs ? req_data[gnt*ENTRY_WIDTH +: ENTRY_WIDTH] : out_data_q;
        out_id_d    = hs ? gnt : out_id_q;
        rr_ptr_d    = hs ? gnt + 1'b1 : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign fifo_enq_valid = out_valid_q;
    assign fifo_enq_data  = out_data_q;
    assign out_id         = out_id_q;
    assign rr_ptr_state   = rr_ptr_q;
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: directed vector table, back-pressure sequence and
// random co-simulation against a behavioural model.
module tb_fifo_enq_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_enq_valid;
    logic [3:0]  fifo_enq_data;
    logic        fifo_enq_ready;
    logic [1:0]  out_id;
    logic [1:0]  rr_ptr_state;

    int tests = 0;
    int fails = 0;

    fifo_enq_arbiter #(.N_REQ(4), .ENTRY_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_enq_valid(fifo_enq_valid),
        .fifo_enq_data(fifo_enq_data),
        .fifo_enq_ready(fifo_enq_ready),
        .out_id(out_id),
        .rr_ptr_state(rr_ptr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [15:0] rd;
        logic        rdy;
        logic [3:0]  er;
        logic        ev;
        logic [3:0]  ed;
        logic [1:0]  eid;
        logic [1:0]  ep;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rv, input logic [15:0] rd, input logic rdy);
        @(negedge clk);
        rst            = r;
        req_valid      = rv;
        req_data       = rd;
        fifo_enq_ready = rdy;
        #1;
    endtask

    logic       m_v;
    logic [3:0] m_d;
    logic [1:0] m_id, m_p, m_g;
    logic [3:0] m_rdy;
    logic       m_found;

    initial begin
        //          rst   rv     data      rdy   ready  v     d      id     ptr
        tbl[0]  = '{1'b1, 4'hF, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0};
        tbl[1]  = '{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[2]  = '{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1, 2'd2};
        tbl[3]  = '{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2, 2'd3};
        tbl[4]  = '{1'b0, 4'hF, 16'hDCBA, 1'b1, 4'h8, 1'b1, 4'hD, 2'd3, 2'd0};
        tbl[5]  = '{1'b0, 4'hF, 16'h1234, 1'b1, 4'h1, 1'b1, 4'h4, 2'd0, 2'd1};
        tbl[6]  = '{1'b0, 4'hF, 16'h1234, 1'b1, 4'h2, 1'b1, 4'h3, 2'd1, 2'd2};
        tbl[7]  = '{1'b0, 4'hF, 16'h1234, 1'b1, 4'h4, 1'b1, 4'h2, 2'd2, 2'd3};
        tbl[8]  = '{1'b0, 4'hF, 16'h1234, 1'b1, 4'h8, 1'b1, 4'h1, 2'd3, 2'd0};
        tbl[9]  = '{1'b0, 4'h2, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1, 2'd2};
        tbl[10] = '{1'b0, 4'h3, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[11] = '{1'b0, 4'h3, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1, 2'd2};
        tbl[12] = '{1'b0, 4'h1, 16'hDCBA, 1'b1, 4'h1, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[13] = '{1'b0, 4'h4, 16'hDCBA, 1'b0, 4'h0, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[14] = '{1'b0, 4'h4, 16'hDCBA, 1'b0, 4'h0, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[15] = '{1'b0, 4'h4, 16'hDCBA, 1'b0, 4'h0, 1'b1, 4'hA, 2'd0, 2'd1};
        tbl[16] = '{1'b0, 4'h4, 16'hDCBA, 1'b1, 4'h4, 1'b1, 4'hC, 2'd2, 2'd3};
        tbl[17] = '{1'b0, 4'h0, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'hC, 2'd2, 2'd3};
        tbl[18] = '{1'b0, 4'h0, 16'hDCBA, 1'b0, 4'h0, 1'b0, 4'hC, 2'd2, 2'd3};
        tbl[19] = '{1'b0, 4'h4, 16'hDCBA, 1'b0, 4'h4, 1'b1, 4'hC, 2'd2, 2'd3};
        tbl[20] = '{1'b1, 4'hF, 16'hDCBA, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0};
        tbl[21] = '{1'b0, 4'h6, 16'hDCBA, 1'b1, 4'h2, 1'b1, 4'hB, 2'd1, 2'd2};
        tbl[22] = '{1'b0, 4'h0, 16'hDCBA, 1'b0, 4'h0, 1'b1, 4'hB, 2'd1, 2'd2};
        tbl[23] = '{1'b0, 4'h8, 16'h5000, 1'b1, 4'h8, 1'b1, 4'h5, 2'd3, 2'd0};

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].er));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d enq_valid", i), 32'(fifo_enq_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d enq_data", i), 32'(fifo_enq_data), 32'(tbl[i].ed));
            chk($sformatf("v%0d out_id", i), 32'(out_id), 32'(tbl[i].eid));
            chk($sformatf("v%0d rr_ptr", i), 32'(rr_ptr_state), 32'(tbl[i].ep));
        end

        // held entry must not move while the FIFO stalls, even as requester data churns
        drive(1'b0, 4'h1, 16'h0007, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h1, 16'(i * 16'h1111 + 16'h0009), 1'b0);
            chk("stall req_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk("stall enq_data", 32'(fifo_enq_data), 32'h7);
            chk("stall enq_valid", 32'(fifo_enq_valid), 32'h1);
        end

        drive(1'b1, 4'h0, 16'h0, 1'b1);
        @(posedge clk);
        m_v = 1'b0; m_d = '0; m_id = '0; m_p = '0;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0), 4'($urandom), 16'($urandom), 1'($urandom));
            m_found = 1'b0;
            m_g     = '0;
            for (int k = 0; k < 4; k++)
                if (!m_found && req_valid[(int'(m_p) + k) % 4]) begin
                    m_found = 1'b1;
                    m_g     = 2'((int'(m_p) + k) % 4);
                end
            m_found = m_found && (!m_v || fifo_enq_ready) && !rst;
            m_rdy   = m_found ? 4'(1 << m_g) : 4'h0;
            chk("rand req_ready", 32'(req_ready), 32'(m_rdy));
            if (rst) begin
                m_v = 1'b0; m_d = '0; m_id = '0; m_p = '0;
            end else if (m_found) begin
                m_v = 1'b1; m_d = req_data[m_g*4 +: 4]; m_id = m_g; m_p = m_g + 2'd1;
            end else if (fifo_enq_ready) begin
                m_v = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand state", {fifo_enq_valid, fifo_enq_data, out_id, rr_ptr_state},
                {m_v, m_d, m_id, m_p});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
